// File: rtl/sdm_sample_sequencer.sv
// sdm_sample_sequencer
//
// Feeds the x1 input of sigma_delta_dac from an upstream valid/ready sample stream. Samples are
// buffered in a small FIFO. Each one is then held on x1 for exactly OSR clock cycles. While
// disabled, the DAC is muted with IDLE_CODE. A period that ends with nothing to play raises a
// sticky underrun flag.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   en            playback enable (sampled at period boundaries while playing)
//   s_valid       upstream sample valid
//   s_ready       FIFO can accept a sample (= !full, no bypass through a same-cycle pop)
//   s_data        upstream sample
//   x1            registered DAC input code
//   sample_tick   one-cycle pulse, high in the first cycle a new sample is on x1
//   underrun      sticky flag: a period ended with an empty FIFO while enabled
//   clr_underrun  clears underrun (a same-cycle set wins)
//   level         FIFO occupancy
module sdm_sample_sequencer #(
  parameter int unsigned     DW          = 4,
  parameter int unsigned     OSR         = 16,
  parameter int unsigned     DEPTH       = 4,
  parameter int unsigned     START_LEVEL = 1,
  parameter logic [DW-1:0]   IDLE_CODE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic [DW-1:0]            x1,
  output logic                     sample_tick,
  output logic                     underrun,
  input  logic                     clr_underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam int unsigned CntW   = $clog2(OSR);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStarved
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable; with DEPTH a power
  // of two the natural binary wrap gives modulo-DEPTH addressing.
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            full, empty;
  logic            push, pop;
  logic [DW-1:0]   head;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PtrW'(DEPTH));
  assign empty   = (level == '0);
  assign s_ready = ~full;
  assign push    = s_valid & s_ready;
  assign head    = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= s_data;
  end

  // ---------------------------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] osr_cnt_q, osr_cnt_d;
  logic [DW-1:0]   x1_q, x1_d;
  logic            tick_q, tick_d;
  logic            underrun_q, underrun_d;
  logic            load;
  logic            underrun_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      osr_cnt_q  <= '0;
      x1_q       <= IDLE_CODE;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      osr_cnt_q  <= osr_cnt_d;
      x1_q       <= x1_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    osr_cnt_d    = osr_cnt_q;
    x1_d         = x1_q;
    tick_d       = 1'b0;
    pop          = 1'b0;
    underrun_set = 1'b0;

    // A load happens when leaving IDLE, or at every period boundary while playing. Checking en
    // only here is what keeps a mid-period disable from truncating the held sample.
    if (state_q == StIdle) begin
      load = en && (level >= PtrW'(START_LEVEL));
    end else begin
      load = (osr_cnt_q == CntW'(OSR - 1));
    end

    if (load) begin
      osr_cnt_d = '0;
      if (en) begin
        if (!empty) begin
          pop     = 1'b1;
          x1_d    = head;
          tick_d  = 1'b1;
          state_d = StRun;
        end else begin
          // Keep the last sample and keep counting so a refill rejoins the original grid.
          underrun_set = 1'b1;
          state_d      = StStarved;
        end
      end else begin
        x1_d    = IDLE_CODE;
        state_d = StIdle;
      end
    end else if (state_q == StIdle) begin
      osr_cnt_d = '0;
    end else begin
      osr_cnt_d = osr_cnt_q + CntW'(1);
    end

    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  assign x1          = x1_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_sdm_sample_sequencer.sv
module tb_sdm_sample_sequencer;

  localparam int DW          = 4;
  localparam int OSR         = 16;
  localparam int DEPTH       = 4;
  localparam int START_LEVEL = 1;
  localparam logic [DW-1:0] IDLE_CODE = 4'd0;

  logic                   clk, rst, en, s_valid, s_ready, sample_tick, underrun, clr_underrun;
  logic [DW-1:0]          s_data, x1;
  logic [$clog2(DEPTH):0] level;

  sdm_sample_sequencer #(
    .DW          (DW),
    .OSR         (OSR),
    .DEPTH       (DEPTH),
    .START_LEVEL (START_LEVEL),
    .IDLE_CODE   (IDLE_CODE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .x1           (x1),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  // Reference model: a sample queue plus "cycles left in the current hold period".
  int q[$];
  bit m_active;   // playing (holding a sample or starved)
  int m_left;     // cycles x1 still has to hold the current value
  int m_x;
  bit m_tick;
  bit m_ur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_left   = 0;
    m_x      = int'(IDLE_CODE);
    m_tick   = 1'b0;
    m_ur     = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic e, input logic c);
    bit accept, is_load, set;
    accept  = v && (q.size() < DEPTH);
    is_load = m_active ? (m_left == 1) : (e && q.size() >= START_LEVEL);
    set     = 1'b0;
    m_tick  = 1'b0;
    if (is_load) begin
      m_left = OSR;
      if (e) begin
        m_active = 1'b1;
        if (q.size() > 0) begin
          m_x    = q.pop_front();
          m_tick = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else begin
        m_x      = int'(IDLE_CODE);
        m_active = 1'b0;
      end
    end else if (m_active) begin
      m_left--;
    end
    if (accept) q.push_back(int'(d));
    if (set) m_ur = 1'b1;
    else if (c) m_ur = 1'b0;
  endtask

  task automatic check_all();
    chk("x1", 32'(x1), 32'(m_x));
    chk("sample_tick", 32'(sample_tick), 32'(m_tick));
    chk("underrun", 32'(underrun), 32'(m_ur));
    chk("level", 32'(level), 32'(q.size()));
    chk("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic e, input logic c);
    s_valid      = v;
    s_data       = d;
    en           = e;
    clr_underrun = c;
    @(posedge clk);
    model_step(v, d, e, c);
    #1;
    tick_cnt += int'(sample_tick);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit found;
    logic ven, vclr, vv;

    // 1: reset
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; clr_underrun = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_x1", 32'(x1), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_tick", 32'(sample_tick), 32'd0);

    // 2: play 3,5,7 then starve
    tick_cnt = 0;
    cycle(1'b1, 4'd3, 1'b1, 1'b0);
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    cycle(1'b1, 4'd7, 1'b1, 1'b0);
    repeat (3 * OSR + 4) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t2_ticks", 32'(tick_cnt), 32'd3);
    chk("t2_x1_last", 32'(x1), 32'd7);
    chk("t2_underrun", 32'(underrun), 32'd1);

    // 3: fill while disabled, overflow attempt, then play
    repeat (OSR + 2) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0);
    cycle(1'b1, 4'd3, 1'b0, 1'b0);
    cycle(1'b1, 4'd4, 1'b0, 1'b0);
    chk("t3_full_ready", 32'(s_ready), 32'd0);
    cycle(1'b1, 4'd9, 1'b0, 1'b0);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_muted", 32'(x1), 32'd0);
    repeat (4 * OSR + 2) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t3_x1_last", 32'(x1), 32'd4);

    // 4: drop en mid-period with two samples still queued
    repeat (OSR + 2) cycle(1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 4'd10, 1'b0, 1'b0);
    cycle(1'b1, 4'd11, 1'b0, 1'b0);
    cycle(1'b1, 4'd12, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t4_first", 32'(x1), 32'd10);
    repeat (5) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    tick_cnt = 0;
    repeat (10) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    chk("t4_held", 32'(x1), 32'd10);
    repeat (2) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    chk("t4_muted", 32'(x1), 32'd0);
    chk("t4_level", 32'(level), 32'd2);
    chk("t4_no_tick", 32'(tick_cnt), 32'd0);

    // 5: clear in the same cycle as an underrun set, then a cycle later
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      found = m_active && (m_left == 1) && (q.size() == 0);
      cycle(1'b0, 4'd0, 1'b1, found);
    end
    chk("t5_reached_set", 32'(found), 32'd1);
    chk("t5_set_wins", 32'(underrun), 32'd1);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    chk("t5_cleared", 32'(underrun), 32'd0);

    // 6: asynchronous reset between edges
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    cycle(1'b1, 4'd6, 1'b1, 1'b0);
    repeat (7) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_x1", 32'(x1), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_s_ready", 32'(s_ready), 32'd1);
    model_reset();
    s_valid = 1'b0; en = 1'b0; clr_underrun = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    repeat (OSR + 3) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t6_idle_x1", 32'(x1), 32'd0);

    // Randomized traffic: dense then sparse arrivals, rare en toggles and clears
    ven = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 63) == 0) ven = ~ven;
      vclr = ($urandom_range(0, 19) == 0);
      if (i < 400) vv = ($urandom_range(0, 7) < 2);
      else         vv = ($urandom_range(0, 31) == 0);
      cycle(vv, DW'($urandom_range(0, 15)), ven, vclr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
